la_deglitch: RTL and testbench
==============================

Name: la_deglitch

Overview:
- Registered glitch-filter stage for the stdlib.
- Sits directly downstream of a combinational cell output such as an OR-AND-invert gate.
- Synchronizes the single-bit input into clk and only passes a level change once it has been stable for a programmable number of cycles.
- Emits one-cycle rise/fall pulses for consumers that want edges rather than levels.

Parameters:
- PROP, "DEFAULT", implementation property string passed through for target-library mapping.
- SYNCSTAGES, 2, number of synchronizer flops; legal range 1..4.
- CNTW, 4, width of the stability counter and of the limit port.
- RSTVAL, 1'b0, reset value of the synchronizer flops and of out.

Ports:
- clk  input  1  clock; all flops are rising-edge.
- nreset  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- in  input  1  raw level from upstream combinational logic; asynchronous to clk.
- en  input  1  filter enable; 0 freezes out and clears the counter.
- limit  input  CNTW  required stable cycles minus one; 0 gives pass-through after synchronization.
- out  output  1  filtered level.
- rise  output  1  one-cycle pulse, coincident with out going 0->1.
- fall  output  1  one-cycle pulse, coincident with out going 1->0.

Behaviour:
- Reset (nreset=0, async):
  - sync chain = RSTVAL; out = RSTVAL.
  - cnt = 0; rise = fall = 0.
- Sync chain: in shifts through SYNCSTAGES flops each edge. s denotes the last stage.
- Per rising edge with en=1:
  - s != out and cnt >= limit: out <= s; cnt <= 0; rise <= s; fall <= ~s.
  - s != out and cnt < limit: cnt <= cnt+1; rise = fall = 0.
  - s == out: cnt <= 0; rise = fall = 0. A glitch shorter than the limit is discarded and the count restarts.
- Per rising edge with en=0:
  - out holds; cnt <= 0; rise = fall = 0.
  - The sync chain keeps running.
- Latency: a clean input step sampled at edge k changes out at edge k+SYNCSTAGES+limit. rise/fall are high for exactly the cycle following that edge.
- limit is sampled every cycle; no latching. If limit drops below the current cnt, out updates on the next edge where s != out.
- Counter never exceeds limit, so it cannot wrap. limit = 2^CNTW-1 is legal and gives the maximum filter of 2^CNTW cycles.
- rise and fall are never high together. Pulses are registered; there is no combinational path from in to any output.
- Reset mid-filtering: all state is discarded immediately. After release, out = RSTVAL and a new qualification starts from cnt=0.
- en re-asserted while s != out: qualification restarts from cnt=0.
- SYNCSTAGES outside 1..4 is a fatal elaboration error.

Decomposition:
- No shared package needed: no typedefs; all constants are module parameters.
- One natural sub-module: la_deglitch_sync.
  - Parameterized SYNCSTAGES-deep, RSTVAL-resettable synchronizer chain on clk/nreset.
  - Marked for synchronizer-cell mapping via PROP.
- The counter/compare/output logic stays in la_deglitch.

Test Plan:
- Reset: nreset=0 with in toggling, RSTVAL=0 -> out=0, rise=fall=0 throughout; after release with in=0, out stays 0.
- Clean step, SYNCSTAGES=2, limit=3: in 0->1 sampled at edge 0 -> out=1 at edge 5; rise high exactly one cycle after edge 5; fall never asserts.
- Glitch rejection, limit=3: in high for 3 cycles then low -> out stays 0; no pulses. Same with a 4-cycle high pulse -> out rises, then falls 4+SYNCSTAGES edges after in drops; one rise and one fall pulse.
- Pass-through, limit=0: alternate in every 2 cycles -> out follows s with 1-edge delay; each transition gives exactly one rise or fall pulse.
- Enable gating: set en=0 while in steps 0->1 and hold 10 cycles -> out stays 0. Set en=1 -> out=1 exactly limit+1 edges later.
- Async reset mid-count: limit=7, assert nreset at cnt=5 -> out=RSTVAL immediately. After release, in held 1 -> full 2+7+1-edge qualification before out=1.

Source files
------------

// File: rtl/la_deglitch_sync.sv
// Resettable multi-flop synchronizer for the la_deglitch input.
// The flop chain sits in a distinctly named generate scope so library flows can find and map it.
module la_deglitch_sync #(
   parameter string PROP       = "DEFAULT",
   parameter int    SYNCSTAGES = 2,
   parameter logic  RSTVAL     = 1'b0
) (
   input  logic clk,
   input  logic nreset,
   input  logic in,
   output logic q
);

   if (PROP == "DEFAULT") begin : g_generic
      (* async_reg = "true" *) logic [SYNCSTAGES-1:0] chain;

      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            chain <= {SYNCSTAGES{RSTVAL}};
         end else begin
            chain[0] <= in;
            for (int i = 1; i < SYNCSTAGES; i++) begin
               chain[i] <= chain[i-1];
            end
         end
      end

      assign q = chain[SYNCSTAGES-1];
   end else begin : g_lib_sync
      // Non-default PROP: the flow swaps this scope for a dedicated synchronizer cell.
      (* async_reg = "true", dont_touch = "true" *) logic [SYNCSTAGES-1:0] chain;

      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            chain <= {SYNCSTAGES{RSTVAL}};
         end else begin
            chain[0] <= in;
            for (int i = 1; i < SYNCSTAGES; i++) begin
               chain[i] <= chain[i-1];
            end
         end
      end

      assign q = chain[SYNCSTAGES-1];
   end

endmodule

// File: rtl/la_deglitch.sv
// Registered glitch filter: synchronizes in, passes a level change only after it has
// been stable for limit+1 cycles, and emits registered one-cycle rise/fall pulses.
module la_deglitch #(
   parameter string PROP       = "DEFAULT",
   parameter int    SYNCSTAGES = 2,
   parameter int    CNTW       = 4,
   parameter logic  RSTVAL     = 1'b0
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            in,
   input  logic            en,
   input  logic [CNTW-1:0] limit,
   output logic            out,
   output logic            rise,
   output logic            fall
);

   if (SYNCSTAGES < 1 || SYNCSTAGES > 4) begin : g_bad_syncstages
      $fatal(1, "la_deglitch: SYNCSTAGES must be within 1..4");
   end

   logic            s;
   logic [CNTW-1:0] cnt;

   la_deglitch_sync #(
      .PROP       (PROP),
      .SYNCSTAGES (SYNCSTAGES),
      .RSTVAL     (RSTVAL)
   ) u_sync (
      .clk    (clk),
      .nreset (nreset),
      .in     (in),
      .q      (s)
   );

   // cnt is cleared whenever it reaches limit, so it never exceeds limit and cannot wrap.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out  <= RSTVAL;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (!en || (s == out)) begin
            cnt <= '0;
         end else if (cnt >= limit) begin
            out  <= s;
            cnt  <= '0;
            rise <= s;
            fall <= ~s;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_la_deglitch.sv
// Directed bench for la_deglitch: a cycle model pushes expected out/rise/fall per edge
// into a queue, popped and compared after each edge, plus latency and pulse-count checks.
module tb_la_deglitch;
   localparam int S  = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          nreset;
   logic          in;
   logic          en;
   logic [CW-1:0] limit;
   logic          out;
   logic          rise;
   logic          fall;

   always #5 clk = ~clk;

   la_deglitch #(
      .PROP       ("DEFAULT"),
      .SYNCSTAGES (S),
      .CNTW       (CW),
      .RSTVAL     (1'b0)
   ) dut (
      .clk    (clk),
      .nreset (nreset),
      .in     (in),
      .en     (en),
      .limit  (limit),
      .out    (out),
      .rise   (rise),
      .fall   (fall)
   );

   typedef struct {
      logic  o;
      logic  r;
      logic  f;
      string tag;
   } exp_t;

   exp_t sb[$];

   logic m_sync[S];
   logic m_out, m_rise, m_fall;
   int   m_cnt;

   int   errors = 0;
   int   checks = 0;
   int   edge_no = 0;
   int   change_edge = -1;
   int   rise_cnt = 0;
   int   fall_cnt = 0;
   logic prev_out = 1'b0;

   task automatic model_reset();
      for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
      m_out  = 1'b0;
      m_cnt  = 0;
      m_rise = 1'b0;
      m_fall = 1'b0;
   endtask

   task automatic model_edge();
      logic ms;
      if (!nreset) begin
         model_reset();
      end else begin
         ms     = m_sync[S-1];
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (!en) m_cnt = 0;
         else if (ms == m_out) m_cnt = 0;
         else if (m_cnt >= int'(limit)) begin
            m_out  = ms;
            m_cnt  = 0;
            m_rise = ms;
            m_fall = !ms;
         end else m_cnt++;
         for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = in;
      end
   endtask

   task automatic check_bit(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(string tag);
      exp_t e;
      model_edge();
      sb.push_back('{m_out, m_rise, m_fall, tag});
      @(posedge clk);
      #1;
      edge_no++;
      e = sb.pop_front();
      check_bit({e.tag, "_out"},  out,  e.o);
      check_bit({e.tag, "_rise"}, rise, e.r);
      check_bit({e.tag, "_fall"}, fall, e.f);
      check_bit({e.tag, "_rise_and_fall"}, rise & fall, 1'b0);
      if (rise === 1'b1) rise_cnt++;
      if (fall === 1'b1) fall_cnt++;
      if (out !== prev_out) change_edge = edge_no;
      prev_out = out;
   endtask

   task automatic run(string tag, int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      int k, rc0, fc0, ce0;

      // Reset held with in toggling
      nreset = 1'b0;
      in     = 1'b0;
      en     = 1'b1;
      limit  = 4'd3;
      model_reset();
      #1;
      check_bit("reset_out", out, 1'b0);
      check_bit("reset_rise", rise, 1'b0);
      check_bit("reset_fall", fall, 1'b0);
      for (int i = 0; i < 4; i++) begin
         in = ~in;
         tick("reset_held");
      end
      in     = 1'b0;
      nreset = 1'b1;
      run("post_reset", 4);
      check_bit("post_reset_level", out, 1'b0);

      // Clean step, limit=3
      rc0 = rise_cnt; fc0 = fall_cnt;
      in = 1'b1;
      k  = edge_no + 1;
      run("step_up", 8);
      check_int("step_up_latency", change_edge, k + S + 3);
      check_int("step_up_rises", rise_cnt - rc0, 1);
      check_int("step_up_falls", fall_cnt - fc0, 0);
      in = 1'b0;
      run("step_down", 8);
      check_bit("step_down_level", out, 1'b0);

      // 3-cycle glitch is rejected
      rc0 = rise_cnt; fc0 = fall_cnt; ce0 = change_edge;
      in = 1'b1;
      run("glitch3_hi", 3);
      in = 1'b0;
      run("glitch3_lo", 8);
      check_int("glitch3_no_change", change_edge, ce0);
      check_int("glitch3_pulses", (rise_cnt - rc0) + (fall_cnt - fc0), 0);

      // 4-cycle pulse passes
      rc0 = rise_cnt; fc0 = fall_cnt;
      in = 1'b1;
      run("pulse4_hi", 4);
      in = 1'b0;
      k  = edge_no + 1;
      run("pulse4_lo", 10);
      check_int("pulse4_fall_latency", change_edge, k + S + 3);
      check_int("pulse4_rises", rise_cnt - rc0, 1);
      check_int("pulse4_falls", fall_cnt - fc0, 1);

      // Pass-through, limit=0
      limit = 4'd0;
      rc0 = rise_cnt; fc0 = fall_cnt;
      k  = edge_no + 1;
      for (int i = 0; i < 4; i++) begin
         in = 1'b1;
         run("pass_hi", 2);
         in = 1'b0;
         run("pass_lo", 2);
      end
      run("pass_flush", 4);
      check_int("pass_rises", rise_cnt - rc0, 4);
      check_int("pass_falls", fall_cnt - fc0, 4);
      check_int("pass_last_latency", change_edge, k + 14 + S);

      // Enable gating
      limit = 4'd3;
      en    = 1'b0;
      in    = 1'b1;
      ce0   = change_edge;
      run("en_off", 10);
      check_bit("en_off_level", out, 1'b0);
      check_int("en_off_no_change", change_edge, ce0);
      en = 1'b1;
      k  = edge_no + 1;
      run("en_on", 6);
      check_int("en_on_latency", change_edge, k + 3);

      // Async reset mid-count (out=1, counting toward 0 with cnt=5)
      limit = 4'd7;
      in    = 1'b0;
      run("midcnt", 7);
      check_bit("midcnt_still_high", out, 1'b1);
      #3;
      nreset = 1'b0;
      #1;
      model_reset();
      check_bit("async_reset_out", out, 1'b0);
      check_bit("async_reset_rise", rise, 1'b0);
      check_bit("async_reset_fall", fall, 1'b0);
      prev_out = out;
      in = 1'b1;
      @(negedge clk);
      run("reset_hold2", 2);
      nreset = 1'b1;
      k = edge_no + 1;
      run("requalify", 12);
      check_int("requalify_latency", change_edge, k + S + 7);

      // Maximum filter, limit=15
      limit = 4'd15;
      in    = 1'b0;
      k     = edge_no + 1;
      run("max_limit", 20);
      check_int("max_limit_latency", change_edge, k + S + 15);

      // limit lowered below current count
      in = 1'b1;
      run("limit_drop_count", 8);
      check_bit("limit_drop_pre", out, 1'b0);
      limit = 4'd2;
      tick("limit_drop");
      check_int("limit_drop_edge", change_edge, edge_no);
      check_bit("limit_drop_level", out, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
